// File: rtl/conv2d_pkg.sv
// Shared constants, pixel type and window indexing helper for the conv2d datapath.
package conv2d_pkg;

    localparam int PACKED_PIXEL_W = 16;
    localparam int DEFAULT_IMG_W  = 32;
    localparam int DEFAULT_IMG_H  = 32;
    localparam int DEFAULT_K      = 3;

    typedef logic [PACKED_PIXEL_W-1:0] pixel_t;

    // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the oldest column.
    function automatic int win_offset(input int r, input int c, input int k, input int pixel_w);
        return ((r * k) + c) * pixel_w;
    endfunction

endpackage

// File: rtl/conv2d_line_buffer_if.sv
// Pixel-in / window-out handshake bundle of the conv2d line buffer.
interface conv2d_line_buffer_if
    import conv2d_pkg::*;
#(
    parameter int PIXEL_W = PACKED_PIXEL_W,
    parameter int K       = DEFAULT_K
);

    logic [PIXEL_W-1:0]     in_pixel;
    logic                   in_valid;
    logic                   in_sof;
    logic                   in_ready;
    logic [K*K*PIXEL_W-1:0] win_data;
    logic                   win_valid;
    logic                   win_ready;
    logic                   frame_done;

    modport master (
        output in_pixel, in_valid, in_sof, win_ready,
        input  in_ready, win_data, win_valid, frame_done
    );

    modport slave (
        input  in_pixel, in_valid, in_sof, win_ready,
        output in_ready, win_data, win_valid, frame_done
    );

endinterface

// File: rtl/conv2d_line_ram.sv
// One image row of pixel storage: combinational read, synchronous write, read returns old data.
module conv2d_line_ram
    import conv2d_pkg::*;
#(
    parameter int DEPTH = DEFAULT_IMG_W,
    parameter int WIDTH = PACKED_PIXEL_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv2d_line_buffer.sv
// Sliding KxK window generator: K-1 line memories feed a shifting window register.
module conv2d_line_buffer
    import conv2d_pkg::*;
#(
    parameter int PIXEL_W = PACKED_PIXEL_W,
    parameter int IMG_W   = DEFAULT_IMG_W,
    parameter int IMG_H   = DEFAULT_IMG_H,
    parameter int K       = DEFAULT_K
) (
    input  logic clk,
    input  logic rst,
    conv2d_line_buffer_if.slave bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = K * K * PIXEL_W;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    logic [CW-1:0]      col_q, cur_col, col_next;
    logic [RW-1:0]      row_q, cur_row, row_next;
    logic [WW-1:0]      win_q, win_next;
    logic               win_valid_q;
    logic               frame_done_q;
    logic               in_ready;
    logic               acc;
    logic [PIXEL_W-1:0] line_rd [K-1];
    logic [PIXEL_W-1:0] line_wr [K-1];

    assign in_ready = !win_valid_q || bus.win_ready;
    assign acc      = bus.in_valid && in_ready;

    // A start-of-frame pixel is always treated as (0,0), overriding the counters.
    assign cur_col = bus.in_sof ? '0 : col_q;
    assign cur_row = bus.in_sof ? '0 : row_q;

    always_comb begin
        col_next = cur_col + CW'(1);
        row_next = cur_row;
        if (cur_col == COL_LAST) begin
            col_next = '0;
            row_next = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    // Lines form a vertical shift chain: each column moves one line older per accepted pixel.
    for (genvar i = 0; i < K - 1; i++) begin : g_line
        if (i == 0) begin : g_first
            assign line_wr[i] = bus.in_pixel;
        end else begin : g_chain
            assign line_wr[i] = line_rd[i-1];
        end

        conv2d_line_ram #(
            .DEPTH(IMG_W),
            .WIDTH(PIXEL_W)
        ) u_ram (
            .clk  (clk),
            .we   (acc),
            .addr (cur_col),
            .wdata(line_wr[i]),
            .rdata(line_rd[i])
        );
    end

    always_comb begin
        win_next = win_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_next[win_offset(r, c, K, PIXEL_W) +: PIXEL_W] =
                    win_q[win_offset(r, c + 1, K, PIXEL_W) +: PIXEL_W];
            end
        end
        // Newest column: oldest line on top, the incoming pixel at the bottom.
        for (int r = 0; r < K - 1; r++) begin
            win_next[win_offset(r, K - 1, K, PIXEL_W) +: PIXEL_W] = line_rd[K-2-r];
        end
        win_next[win_offset(K - 1, K - 1, K, PIXEL_W) +: PIXEL_W] = bus.in_pixel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= acc && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            if (acc) begin
                col_q       <= col_next;
                row_q       <= row_next;
                win_q       <= win_next;
                win_valid_q <= (cur_row >= ROW_WIN) && (cur_col >= COL_WIN);
            end else if (bus.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.win_data   = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2d_line_buffer.sv
// Scoreboard bench for conv2d_line_buffer on an 8x6 image with 3x3 windows.
module tb_conv2d_line_buffer;
    import conv2d_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int K     = 3;
    localparam int PW    = 16;
    localparam int WW    = K * K * PW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv2d_line_buffer_if #(.PIXEL_W(PW), .K(K)) bus ();

    conv2d_line_buffer #(
        .PIXEL_W(PW),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int win_seen, fd_seen, win_pushed, fd_expected;
    int m_row, m_col;
    bit rand_ready = 1'b0;
    bit gaps = 1'b0;
    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] first_win, last_win;
    pixel_t img [IMG_H][IMG_W];

    function automatic pixel_t pix(input int r, input int c);
        return pixel_t'(r * 16 + c);
    endfunction

    // Window whose bottom-right pixel sits at frame coordinate (br,bc).
    function automatic logic [WW-1:0] win_at(input int br, input int bc);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[((r * K) + c) * PW +: PW] = pix(br - K + 1 + r, bc - K + 1 + c);
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.win_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_accept(input pixel_t p, input bit sof,
                                output bit wexp, output bit fexp, output logic [WW-1:0] w);
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = p;
        wexp = (m_row >= K - 1) && (m_col >= K - 1);
        fexp = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
        w = '0;
        if (wexp) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    w[((r * K) + c) * PW +: PW] = img[m_row - K + 1 + r][m_col - K + 1 + c];
            exp_q.push_back(w);
            win_pushed++;
        end
        if (fexp) fd_expected++;
        m_col++;
        if (m_col == IMG_W) begin
            m_col = 0;
            m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end
    endtask

    task automatic apply_stimulus(input pixel_t p, input bit sof);
        bit wexp, fexp, accepted;
        logic [WW-1:0] w;
        wexp = 1'b0;
        fexp = 1'b0;
        accepted = 1'b0;
        w = '0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            bus.in_valid = 1'b0;
            bus.in_sof = 1'b0;
            tick();
        end
        bus.in_pixel = p;
        bus.in_sof = sof;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(p, sof, wexp, fexp, w);
                accepted = 1'b1;
            end
            tick();
        end
        if (!accepted) begin
            tests++;
            fails++;
            $error("[TB] FAIL accept_timeout: observed no accept, expected accept within 200 cycles");
        end else begin
            check_output("win_valid_after_accept", WW'(bus.win_valid), WW'(wexp));
            check_output("frame_done_after_accept", WW'(bus.frame_done), WW'(fexp));
            if (wexp) check_output("win_data_after_accept", bus.win_data, w);
        end
    endtask

    task automatic send_frame(input bit sof_first);
        for (int i = 0; i < IMG_W * IMG_H; i++)
            apply_stimulus(pix(i / IMG_W, i % IMG_W), sof_first && i == 0);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || bus.win_valid); i++) tick();
        if (exp_q.size() != 0 || bus.win_valid) begin
            tests++;
            fails++;
            $error("[TB] FAIL drain_timeout: observed %0d windows pending, expected 0", exp_q.size());
        end
        rand_ready = 1'b0;
        bus.win_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic start_scn();
        win_seen = 0;
        fd_seen = 0;
        win_pushed = 0;
        fd_expected = 0;
    endtask

    task automatic end_scn(input string tag, input int n_win, input int n_fd);
        check_output({tag, "_windows"}, WW'(win_seen), WW'(n_win));
        check_output({tag, "_windows_vs_model"}, WW'(win_seen), WW'(win_pushed));
        check_output({tag, "_frame_done"}, WW'(fd_seen), WW'(n_fd));
    endtask

    // Output monitor: retires windows against the scoreboard and counts frame_done pulses.
    always @(negedge clk) begin
        logic [WW-1:0] e;
        if (!rst) begin
            if (bus.frame_done) begin
                fd_seen++;
                check_output("frame_done_with_win_valid", WW'(bus.win_valid), WW'(1));
            end
            if (bus.win_valid && bus.win_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("[TB] FAIL unexpected_window: observed %h expected none", bus.win_data);
                end else begin
                    e = exp_q.pop_front();
                    check_output("window_seq", bus.win_data, e);
                end
                if (win_seen == 0) first_win = bus.win_data;
                last_win = bus.win_data;
                win_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst = 1'b1;
        bus.in_pixel = '0;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.win_ready = 1'b1;
        m_row = 0;
        m_col = 0;
        start_scn();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_in_ready", WW'(bus.in_ready), WW'(1));
        check_output("reset_win_valid", WW'(bus.win_valid), WW'(0));
        check_output("reset_frame_done", WW'(bus.frame_done), WW'(0));
        check_output("reset_win_data", bus.win_data, '0);
        tick();
        rst = 1'b0;
        tick();

        // Full frame, continuous input, always ready.
        start_scn();
        send_frame(1'b1);
        drain();
        end_scn("full", 24, 1);
        check_output("first_win_00", WW'(first_win[0 +: PW]), WW'(16'h0000));
        check_output("first_win_11", WW'(first_win[4 * PW +: PW]), WW'(16'h0011));
        check_output("first_win_22", WW'(first_win[8 * PW +: PW]), WW'(16'h0022));
        check_output("last_win_22", WW'(last_win[8 * PW +: PW]), WW'(16'h0057));

        // Five-cycle stall on the first window.
        start_scn();
        for (int i = 0; i < 2 * IMG_W + 2; i++)
            apply_stimulus(pix(i / IMG_W, i % IMG_W), i == 0);
        bus.win_ready = 1'b0;
        apply_stimulus(pix(2, 2), 1'b0);
        bus.in_pixel = pix(2, 3);
        bus.in_sof = 1'b0;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_output("stall_in_ready", WW'(bus.in_ready), WW'(0));
            check_output("stall_win_valid", WW'(bus.win_valid), WW'(1));
            check_output("stall_win_data", bus.win_data, win_at(2, 2));
            tick();
        end
        bus.win_ready = 1'b1;
        for (int i = 2 * IMG_W + 3; i < IMG_W * IMG_H; i++)
            apply_stimulus(pix(i / IMG_W, i % IMG_W), 1'b0);
        drain();
        end_scn("backpressure", 24, 1);

        // Random input gaps and random downstream ready.
        start_scn();
        gaps = 1'b1;
        rand_ready = 1'b1;
        send_frame(1'b1);
        gaps = 1'b0;
        drain();
        end_scn("random", 24, 1);

        // Reset after pixel (3,4), then a frame without in_sof.
        for (int i = 0; i < 3 * IMG_W + 5; i++)
            apply_stimulus(pix(i / IMG_W, i % IMG_W), i == 0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        check_output("midreset_win_valid", WW'(bus.win_valid), WW'(0));
        check_output("midreset_frame_done", WW'(bus.frame_done), WW'(0));
        check_output("midreset_win_data", bus.win_data, '0);
        tick();
        rst = 1'b0;
        start_scn();
        send_frame(1'b0);
        drain();
        end_scn("reset_restart", 24, 1);

        // in_sof on pixel (1,3) restarts the frame there.
        start_scn();
        for (int i = 0; i < IMG_W + 3; i++)
            apply_stimulus(pix(i / IMG_W, i % IMG_W), i == 0);
        send_frame(1'b1);
        drain();
        end_scn("sof_restart", 24, 1);

        // Two frames back to back.
        start_scn();
        send_frame(1'b1);
        send_frame(1'b1);
        drain();
        end_scn("two_frames", 48, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
